// File: rtl/sram_readout_ctrl_if.sv
// Bus bundle between the SRAM readout controller and its environment (capture block,
// SRAM data bus and MCU side). The controller connects to the slave modport.
interface sram_readout_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              Write_Ready;
  logic [ADDR_W-1:0] ADDR_CNT_IN;
  logic [ADDR_W-1:0] Read_Len;
  logic              Start_Read;
  logic              Rd_Req;
  logic [15:0]       SRAM_DATA;
  logic              SRAM_OE_n;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       DATA_OUT;
  logic              Data_Valid;
  logic              Read_Busy;
  logic              Read_Done;

  modport master (
    output Write_Ready, ADDR_CNT_IN, Read_Len, Start_Read, Rd_Req, SRAM_DATA,
    input  SRAM_OE_n, SRAM_ADDR, DATA_OUT, Data_Valid, Read_Busy, Read_Done
  );

  modport slave (
    input  Write_Ready, ADDR_CNT_IN, Read_Len, Start_Read, Rd_Req, SRAM_DATA,
    output SRAM_OE_n, SRAM_ADDR, DATA_OUT, Data_Valid, Read_Busy, Read_Done
  );
endinterface

// File: rtl/sram_readout_ctrl.sv
// Streams words out of the frozen circular sample SRAM, oldest sample first, one word per
// MCU strobe; SRAM is only driven while capture is stopped.
module sram_readout_ctrl #(
  parameter int unsigned SRAM_LAT = 2,
  parameter int unsigned ADDR_W   = 18
) (
  input logic               CLK,
  input logic               RST,
  sram_readout_ctrl_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StArm, StReady, StFetch, StDone} state_e;

  localparam logic [2:0] LatLast = 3'(SRAM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [2:0]        lat_q, lat_d;
  logic [15:0]       data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.Start_Read) begin
          if (bus.Read_Len == '0) begin
            state_d = StDone;
          end else if (bus.Write_Ready) begin
            state_d = StReady;
            addr_d  = bus.ADDR_CNT_IN + 1'b1;
            rem_d   = bus.Read_Len;
          end else begin
            state_d = StArm;
          end
        end
      end
      StArm: begin
        if (bus.Write_Ready) begin
          state_d = StReady;
          addr_d  = bus.ADDR_CNT_IN + 1'b1;
          rem_d   = bus.Read_Len;
        end
      end
      StReady: begin
        if (!bus.Write_Ready) begin
          state_d = StIdle;
        end else if (bus.Rd_Req) begin
          state_d = StFetch;
          lat_d   = LatLast;
        end
      end
      StFetch: begin
        // A new capture has started: drop the access without delivering the word.
        if (!bus.Write_Ready) begin
          state_d = StIdle;
        end else if (lat_q == 3'd0) begin
          data_d  = bus.SRAM_DATA;
          valid_d = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == ADDR_W'(1)) ? StDone : StReady;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= 3'd0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Gating with Write_Ready keeps OE off in the very cycle capture restarts.
  assign bus.SRAM_OE_n  = !((state_q == StFetch) && bus.Write_Ready);
  assign bus.SRAM_ADDR  = addr_q;
  assign bus.DATA_OUT   = data_q;
  assign bus.Data_Valid = valid_q;
  assign bus.Read_Busy  = (state_q == StArm) || (state_q == StReady) || (state_q == StFetch);
  assign bus.Read_Done  = (state_q == StDone);

endmodule

// File: tb/tb_sram_readout_ctrl.sv
// Randomized bench for sram_readout_ctrl against a transaction-level model of the
// oldest-first circular readout.
module tb_sram_readout_ctrl;
  localparam int unsigned LAT = 2;
  localparam int unsigned AW  = 18;

  logic CLK = 1'b0;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  logic [15:0] key;
  bit   mon_en = 0;

  sram_readout_ctrl_if #(.ADDR_W(AW)) bus ();

  sram_readout_ctrl #(.SRAM_LAT(LAT), .ADDR_W(AW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // SRAM contents: a keyed hash of the address.
  function automatic logic [15:0] sram_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {14'b0, a} * 32'h9E3779B1;
    return h[31:16] ^ key;
  endfunction

  assign bus.SRAM_DATA = sram_word(bus.SRAM_ADDR);

  // Continuous invariants: no OE while capturing, address stable during an access.
  logic          prev_oe;
  logic [AW-1:0] prev_addr;
  always @(negedge CLK) begin
    #2;
    if (mon_en) begin
      checks++;
      if (!bus.SRAM_OE_n && !bus.Write_Ready) begin
        failures++;
        $display("FAIL mon_oe_wr: OE_n=0 while Write_Ready=0 at %0t", $time);
      end
      checks++;
      if (!prev_oe && !bus.SRAM_OE_n && bus.SRAM_ADDR !== prev_addr) begin
        failures++;
        $display("FAIL mon_addr_stable: addr %h -> %h with OE_n low", prev_addr, bus.SRAM_ADDR);
      end
    end
    prev_oe   = bus.SRAM_OE_n;
    prev_addr = bus.SRAM_ADDR;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_session(input logic [AW-1:0] cnt, input logic [AW-1:0] len);
    @(negedge CLK);
    bus.ADDR_CNT_IN = cnt;
    bus.Read_Len    = len;
    bus.Start_Read  = 1'b1;
    @(negedge CLK);
    bus.Start_Read  = 1'b0;
  endtask

  // Called at a negedge with the DUT in READY; returns at the Data_Valid negedge.
  task automatic read_word(input logic [AW-1:0] exp_addr, input bit last, input string name);
    int lat;
    int oe_low;
    bit got;
    bus.Rd_Req = 1'b1;
    lat = 0; oe_low = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      bus.Rd_Req = 1'b0;
      lat++;
      if (bus.Data_Valid) got = 1;
      else if (!bus.SRAM_OE_n) begin
        oe_low++;
        checks++;
        if (bus.SRAM_ADDR !== exp_addr) begin
          failures++;
          $display("FAIL %s fetch_addr: got %h exp %h", name, bus.SRAM_ADDR, exp_addr);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no Data_Valid within 20 cycles, exp addr %h", name, exp_addr);
    end else begin
      checks += 7;
      if (lat != LAT + 1) begin
        failures++; $display("FAIL %s latency: got %0d exp %0d", name, lat, LAT + 1);
      end
      if (oe_low != LAT) begin
        failures++; $display("FAIL %s oe_cycles: got %0d exp %0d", name, oe_low, LAT);
      end
      if (bus.DATA_OUT !== sram_word(exp_addr)) begin
        failures++; $display("FAIL %s data: got %h exp %h", name, bus.DATA_OUT, sram_word(exp_addr));
      end
      if (bus.Read_Done !== last) begin
        failures++; $display("FAIL %s done: got %b exp %b", name, bus.Read_Done, last);
      end
      if (bus.Read_Busy !== !last) begin
        failures++; $display("FAIL %s busy: got %b exp %b", name, bus.Read_Busy, !last);
      end
      if (bus.SRAM_OE_n !== 1'b1) begin
        failures++; $display("FAIL %s oe_after: got %b exp 1", name, bus.SRAM_OE_n);
      end
      if (bus.SRAM_ADDR !== AW'(exp_addr + 1)) begin
        failures++; $display("FAIL %s addr_inc: got %h exp %h", name, bus.SRAM_ADDR, AW'(exp_addr + 1));
      end
    end
  endtask

  task automatic run_session(input logic [AW-1:0] cnt, input int len, input int max_gap,
                             input string name);
    logic [AW-1:0] base;
    base = AW'(cnt + 1);
    start_session(cnt, AW'(len));
    checks += 2;
    if (bus.Read_Busy !== 1'b1) begin
      failures++; $display("FAIL %s start_busy: got %b exp 1", name, bus.Read_Busy);
    end
    if (bus.SRAM_ADDR !== base) begin
      failures++; $display("FAIL %s start_addr: got %h exp %h", name, bus.SRAM_ADDR, base);
    end
    for (int i = 0; i < len; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        checks++;
        if (bus.Data_Valid !== 1'b0 || bus.SRAM_OE_n !== 1'b1) begin
          failures++;
          $display("FAIL %s idle_gap: valid=%b oe_n=%b exp 0/1", name, bus.Data_Valid, bus.SRAM_OE_n);
        end
      end
      read_word(AW'(base + AW'(i)), (i == len - 1), name);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.SRAM_OE_n !== 1'b1) begin failures++; $display("FAIL reset oe_n: got %b exp 1", bus.SRAM_OE_n); end
    if (bus.SRAM_ADDR !== '0) begin failures++; $display("FAIL reset addr: got %h exp 0", bus.SRAM_ADDR); end
    if (bus.DATA_OUT !== 16'h0) begin failures++; $display("FAIL reset data: got %h exp 0", bus.DATA_OUT); end
    if (bus.Data_Valid !== 1'b0) begin failures++; $display("FAIL reset valid: got %b exp 0", bus.Data_Valid); end
    if (bus.Read_Busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b exp 0", bus.Read_Busy); end
    if (bus.Read_Done !== 1'b0) begin failures++; $display("FAIL reset done: got %b exp 0", bus.Read_Done); end
  endtask

  task automatic test_basic();
    run_session(AW'(18'h00010), 4, 0, "basic");
  endtask

  task automatic test_wrap();
    run_session(AW'(18'h3FFFE), 3, 1, "wrap");
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      logic [AW-1:0] cnt;
      cnt = (s % 2 == 0) ? AW'($urandom) : AW'(18'h3FFFF - AW'($urandom_range(3, 0)));
      run_session(cnt, int'($urandom_range(6, 1)), 3, "random");
    end
  endtask

  task automatic test_arm_wait();
    logic [AW-1:0] cnt;
    logic [AW-1:0] held;
    held = bus.SRAM_ADDR;
    cnt  = AW'(held + 100);
    bus.Write_Ready = 1'b0;
    start_session(cnt, AW'(2));
    for (int i = 0; i < 10; i++) begin
      bus.Rd_Req = (i == 4);
      checks++;
      if (bus.SRAM_OE_n !== 1'b1 || bus.Read_Busy !== 1'b1 || bus.SRAM_ADDR !== held) begin
        failures++;
        $display("FAIL arm_wait cycle %0d: oe_n=%b busy=%b addr=%h exp 1/1/%h", i,
                 bus.SRAM_OE_n, bus.Read_Busy, bus.SRAM_ADDR, held);
      end
      @(negedge CLK);
    end
    bus.Rd_Req = 1'b0;
    bus.Write_Ready = 1'b1;
    @(negedge CLK);
    checks++;
    if (bus.SRAM_ADDR !== AW'(cnt + 1) || bus.Read_Busy !== 1'b1) begin
      failures++;
      $display("FAIL arm_ready: addr=%h busy=%b exp %h/1", bus.SRAM_ADDR, bus.Read_Busy, AW'(cnt + 1));
    end
    read_word(AW'(cnt + 1), 1'b0, "arm_w0");
    read_word(AW'(cnt + 2), 1'b1, "arm_w1");
  endtask

  task automatic test_abort();
    logic [AW-1:0] cnt;
    cnt = AW'($urandom);
    start_session(cnt, AW'(4));
    read_word(AW'(cnt + 1), 1'b0, "abort_w0");
    bus.Rd_Req = 1'b1;
    @(negedge CLK);
    bus.Rd_Req = 1'b0;
    checks++;
    if (bus.SRAM_OE_n !== 1'b0) begin
      failures++; $display("FAIL abort in_fetch: oe_n got %b exp 0", bus.SRAM_OE_n);
    end
    bus.Write_Ready = 1'b0;
    #1;
    checks++;
    if (bus.SRAM_OE_n !== 1'b1) begin
      failures++; $display("FAIL abort oe_comb: oe_n got %b exp 1", bus.SRAM_OE_n);
    end
    @(negedge CLK);
    checks++;
    if (bus.Read_Busy !== 1'b0 || bus.Read_Done !== 1'b0 || bus.SRAM_OE_n !== 1'b1
        || bus.Data_Valid !== 1'b0) begin
      failures++;
      $display("FAIL abort idle: busy=%b done=%b oe_n=%b valid=%b exp 0/0/1/0",
               bus.Read_Busy, bus.Read_Done, bus.SRAM_OE_n, bus.Data_Valid);
    end
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.Data_Valid !== 1'b0) begin
        failures++; $display("FAIL abort late_valid: got %b exp 0", bus.Data_Valid);
      end
    end
    bus.Write_Ready = 1'b1;
  endtask

  task automatic test_len_zero();
    start_session(AW'($urandom), AW'(0));
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.Read_Done !== 1'b1 || bus.Read_Busy !== 1'b0 || bus.SRAM_OE_n !== 1'b1) begin
        failures++;
        $display("FAIL len_zero cycle %0d: done=%b busy=%b oe_n=%b exp 1/0/1", i,
                 bus.Read_Done, bus.Read_Busy, bus.SRAM_OE_n);
      end
      @(negedge CLK);
    end
    // Restart from DONE behaves like a start from IDLE.
    run_session(AW'($urandom), 2, 1, "restart");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] cnt;
    int nv;
    cnt = AW'($urandom);
    nv  = 0;
    start_session(cnt, AW'(3));
    bus.Rd_Req = 1'b1;
    for (int cyc = 1; cyc <= 3 * (LAT + 1) + 4; cyc++) begin
      @(negedge CLK);
      bus.Start_Read = (cyc == 1);
      if (cyc == 1) begin
        bus.ADDR_CNT_IN = AW'(cnt + 18'h55);
        bus.Read_Len    = AW'(7);
      end
      if (bus.Data_Valid) begin
        checks += 3;
        if (nv >= 3) begin
          failures++; $display("FAIL b2b extra_valid: valid %0d at cycle %0d exp none", nv, cyc);
        end else begin
          if (cyc != (nv + 1) * (LAT + 1)) begin
            failures++;
            $display("FAIL b2b spacing: word %0d at cycle %0d exp %0d", nv, cyc, (nv + 1) * (LAT + 1));
          end
          if (bus.DATA_OUT !== sram_word(AW'(cnt + 1 + AW'(nv)))) begin
            failures++;
            $display("FAIL b2b data: word %0d got %h exp %h", nv, bus.DATA_OUT,
                     sram_word(AW'(cnt + 1 + AW'(nv))));
          end
          if (bus.Read_Done !== (nv == 2)) begin
            failures++; $display("FAIL b2b done: word %0d got %b exp %b", nv, bus.Read_Done, nv == 2);
          end
        end
        nv++;
      end
    end
    bus.Rd_Req     = 1'b0;
    bus.Start_Read = 1'b0;
    checks++;
    if (nv != 3 || bus.Read_Done !== 1'b1) begin
      failures++; $display("FAIL b2b total: words=%0d done=%b exp 3/1", nv, bus.Read_Done);
    end
  endtask

  task automatic test_reset_in_fetch();
    start_session(AW'($urandom), AW'(3));
    bus.Rd_Req = 1'b1;
    @(negedge CLK);
    bus.Rd_Req = 1'b0;
    checks++;
    if (bus.SRAM_OE_n !== 1'b0) begin
      failures++; $display("FAIL rst_fetch in_fetch: oe_n got %b exp 0", bus.SRAM_OE_n);
    end
    RST = 1'b1;
    @(negedge CLK);
    test_reset();
    RST = 1'b0;
  endtask

  initial begin
    bus.Write_Ready = 1'b1;
    bus.ADDR_CNT_IN = '0;
    bus.Read_Len    = '0;
    bus.Start_Read  = 1'b0;
    bus.Rd_Req      = 1'b0;
    key = 16'($urandom);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    test_reset();
    RST = 1'b0;
    mon_en = 1;
    test_basic();
    test_wrap();
    test_random();
    test_arm_wait();
    test_abort();
    test_len_zero();
    test_back_to_back();
    test_reset_in_fetch();
    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_readout_ctrl.md
# sram_readout_ctrl

Readout stage that sits directly downstream of the capture/synchronization block. Once capture is finished (Write_Ready high), it converts the final write address of the circular sample SRAM into the oldest-sample address. It then streams a requested number of 16-bit sample words (channel B in the high byte, channel A in the low byte) to the MCU interface, one word per MCU read strobe, wrapping at the top of the address space. It drives the SRAM read strobe and address only while capture is stopped, so reads never collide with the capture write strobe.

## Interface
- SRAM_LAT, 2, SRAM access cycles with SRAM_OE_n low before data is sampled (legal 1..7)
- ADDR_W, 18, SRAM address width; the buffer depth is 2^ADDR_W
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- Write_Ready  in  1  capture complete; high means SRAM contents are frozen
- ADDR_CNT_IN  in  ADDR_W  last address written by the capture counter
- Read_Len  in  ADDR_W  number of words to read; 0 means no read
- Start_Read  in  1  one-cycle pulse that begins a readout session
- Rd_Req  in  1  one-cycle MCU strobe requesting the next word
- SRAM_DATA  in  16  SRAM read data bus
- SRAM_OE_n  out  1  SRAM output enable, active low
- SRAM_ADDR  out  ADDR_W  SRAM read address
- DATA_OUT  out  16  last word fetched, held until the next fetch
- Data_Valid  out  1  one-cycle pulse when DATA_OUT updates
- Read_Busy  out  1  session active (ARM, READY or FETCH)
- Read_Done  out  1  level; high after the last word until the next Start_Read, RST or abort

## Operation
- States:
  - IDLE: waits for a session start.
  - ARM: waits for capture to finish.
  - READY: waits for the next MCU strobe.
  - FETCH: SRAM access in progress.
  - DONE: all requested words delivered.
- IDLE, Start_Read=1:
  - Read_Len=0: go to DONE.
  - Write_Ready=1: go to READY.
  - Write_Ready=0: go to ARM.
- ARM: go to READY on the first cycle with Write_Ready=1.
- Entering READY from IDLE or ARM:
  - SRAM_ADDR <= ADDR_CNT_IN + 1, computed modulo 2^ADDR_W; this is the oldest sample.
  - Remaining-word counter <= Read_Len.
- READY, Rd_Req=1: go to FETCH, load latency counter, drive SRAM_OE_n=0.
- FETCH lasts exactly SRAM_LAT cycles. On its last cycle:
  - DATA_OUT <= SRAM_DATA.
  - SRAM_ADDR increments modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
  - Remaining counter decrements.
  - Next state is DONE if the counter reaches 0, otherwise READY.
- Abort: Write_Ready falling while in READY or FETCH means a new capture has started.
  - Go to IDLE on the next edge.
  - SRAM_OE_n=1, Read_Busy=0, Read_Done=0.
  - No Data_Valid is issued for the interrupted fetch.
- Ignored inputs:
  - Start_Read while in ARM, READY or FETCH.
  - Rd_Req outside READY, including during FETCH (no queueing).
- DONE:
  - Start_Read restarts the session exactly as from IDLE.
  - Rd_Req is ignored.
- Simultaneous RST with any input: RST wins.
- Widths:
  - Remaining counter is ADDR_W bits.
  - Latency counter is 3 bits.
  - Address arithmetic is unsigned with natural wrap.

## Timing
- Reset values:
  - State IDLE.
  - SRAM_OE_n=1, SRAM_ADDR=0, DATA_OUT=0.
  - Data_Valid=0, Read_Busy=0, Read_Done=0.
- Start_Read at edge N with Write_Ready=1: at N+1, Read_Busy=1 and SRAM_ADDR=ADDR_CNT_IN+1.
- Rd_Req at edge M in READY:
  - SRAM_OE_n=0 during M+1 .. M+SRAM_LAT.
  - SRAM_DATA is sampled at edge M+SRAM_LAT.
  - DATA_OUT updates and Data_Valid=1 for the single cycle after that edge.
  - SRAM_OE_n=1 and the incremented SRAM_ADDR are visible in that same cycle.
- Request-to-data latency is SRAM_LAT+1 cycles. Back-to-back throughput is one word per SRAM_LAT+1 cycles.
- The earliest Rd_Req accepted after a word is the cycle in which Data_Valid=1.
- Last word:
  - Read_Done=1 and Read_Busy=0 in the same cycle as its Data_Valid.
  - Both hold until the next Start_Read or RST.
- SRAM_ADDR changes only while SRAM_OE_n=1.
- SRAM_OE_n is never 0 while Write_Ready=0.

## Test plan
- Basic read, SRAM_LAT=2:
  - Stimulus: ADDR_CNT_IN=0x00010, Read_Len=4, Start_Read, then 4 Rd_Req.
  - Required: addresses 0x00011..0x00014; each Data_Valid 3 cycles after its Rd_Req; Read_Done with the 4th word.
- Wrap-around:
  - Stimulus: ADDR_CNT_IN=0x3FFFE, Read_Len=3.
  - Required: SRAM_ADDR sequence 0x3FFFF, 0x00000, 0x00001.
- Arm wait:
  - Stimulus: Start_Read with Write_Ready=0; Write_Ready rises 10 cycles later.
  - Required: SRAM_OE_n stays 1 for all 10 cycles; READY is entered on the next edge after the rise.
- Abort mid-fetch:
  - Stimulus: Write_Ready falls during the FETCH of word 2.
  - Required: no Data_Valid for word 2; IDLE, OE_n=1, Read_Busy=0 the next cycle.
- Ignored strobes:
  - Stimulus: Rd_Req asserted every cycle.
  - Required: exactly one fetch per SRAM_LAT+1 cycles; a Start_Read during FETCH has no effect.
- Corner cases:
  - Read_Len=0 gives DONE in one cycle with no OE_n pulse.
  - RST asserted in FETCH restores all reset values on the next edge.
